// File: rtl/rr_arb_param.sv
// Round-robin arbiter for N requesters with registered one-hot grant,
// bounded tenure (MAX_HOLD) and per-holder lock extension.
module rr_arb_param #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_in,
  input  logic [N-1:0]         lock_in,
  output logic [N-1:0]         gnt_out,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);
  localparam int HC_W  = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HC_W-1:0]  hold_cnt;

  logic [IDX_W-1:0] nxt_ptr;
  logic [IDX_W-1:0] arb_ptr;
  logic [N-1:0]     masked;
  logic [IDX_W-1:0] win;
  logic             win_any;
  logic             tenure_end;

  // Lowest set bit wins; caller guarantees a non-zero vector when it matters.
  function automatic logic [IDX_W-1:0] first_set(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  function automatic logic [N-1:0] upper_mask(input logic [IDX_W-1:0] p);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++)
      m[i] = (i >= int'(p));
    return m;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  // Arbitration uses the post-rotation pointer while a tenure is ending,
  // so the next winner is granted on the same edge the holder releases.
  always_comb begin
    nxt_ptr    = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    tenure_end = !req_in[gnt_idx] ||
                 ((hold_cnt >= HC_W'(MAX_HOLD)) && !lock_in[gnt_idx]);
    arb_ptr    = (state == GRANT) ? nxt_ptr : ptr;
    masked     = req_in & upper_mask(arb_ptr);
    win_any    = |req_in;
    win        = (|masked) ? first_set(masked) : first_set(req_in);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_out   <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            gnt_out   <= onehot(win);
            gnt_valid <= 1'b1;
            gnt_idx   <= win;
            hold_cnt  <= HC_W'(1);
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!tenure_end) begin
            if (hold_cnt < HC_W'(MAX_HOLD))
              hold_cnt <= hold_cnt + 1'b1;
          end else begin
            ptr <= nxt_ptr;
            if (win_any) begin
              gnt_out   <= onehot(win);
              gnt_valid <= 1'b1;
              gnt_idx   <= win;
              hold_cnt  <= HC_W'(1);
            end else begin
              gnt_out   <= '0;
              gnt_valid <= 1'b0;
              gnt_idx   <= '0;
              hold_cnt  <= '0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_param.sv
// Directed bench for rr_arb_param (N=4, MAX_HOLD=4): vector table plus
// hand-written lock and sole-requester sequences.
module tb_rr_arb_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_in;
  logic [3:0] lock_in;
  logic [3:0] gnt_out;
  logic       gnt_valid;
  logic [1:0] gnt_idx;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [1:0] idx;
    string      name;
  } vec_t;

  vec_t tbl[$];

  rr_arb_param #(.N(4), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .lock_in  (lock_in),
    .gnt_out  (gnt_out),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] l,
                              input logic [3:0] g, input logic [1:0] i, input string nm);
    vec_t v;
    v.rst_n = r; v.req = q; v.lock = l; v.gnt = g; v.idx = i; v.name = nm;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] l);
    rst_n   = r;
    req_in  = q;
    lock_in = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [3:0] g, input logic [1:0] i);
    logic v;
    v = |g;
    n_tests++;
    if (gnt_out !== g || gnt_idx !== i || gnt_valid !== v) begin
      n_fail++;
      $display("FAIL %s: got gnt_out=%b gnt_idx=%0d gnt_valid=%b, expected %b/%0d/%b",
               nm, gnt_out, gnt_idx, gnt_valid, g, i, v);
    end
  endtask

  initial begin
    logic [3:0] one;
    one     = 4'b0001;
    rst_n   = 1'b0;
    req_in  = '0;
    lock_in = '0;

    // Reset, then steady contention: 4 cycles per requester, wrap to 0.
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, "reset");
    for (int k = 0; k < 17; k++)
      add(1, 4'b1111, 4'b0000, one << ((k / 4) % 4), 2'((k / 4) % 4), "steady");

    // Single pulse.
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, "reset2");
    add(1, 4'b0100, 4'b0000, 4'b0100, 2'd2, "pulse_gnt");
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "pulse_rel");
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "pulse_idle");

    // Early release handover, then pointer wrap checks from IDLE.
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, "reset3");
    add(1, 4'b0101, 4'b0000, 4'b0001, 2'd0, "early_c1");
    add(1, 4'b0101, 4'b0000, 4'b0001, 2'd0, "early_c2");
    add(1, 4'b0100, 4'b0000, 4'b0100, 2'd2, "early_handover");
    add(1, 4'b0100, 4'b0000, 4'b0100, 2'd2, "early_hold2");
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "early_idle");
    add(1, 4'b0011, 4'b0000, 4'b0001, 2'd0, "ptr3_wrap");
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "ptr3_rel");
    add(1, 4'b0011, 4'b0000, 4'b0010, 2'd1, "ptr1_pick");
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "ptr1_rel");

    // Reset in the middle of requester 2's tenure.
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, "reset4");
    for (int k = 0; k < 9; k++)
      add(1, 4'b1111, 4'b0000, one << (k / 4), 2'(k / 4), "pre_rst");
    add(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, "mid_rst");
    add(1, 4'b1111, 4'b0000, 4'b0001, 2'd0, "post_rst");

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].req, tbl[i].lock);
      check(tbl[i].name, tbl[i].gnt, tbl[i].idx);
    end

    // Lock: requester 1 keeps the grant 10 cycles, lock drop hands over.
    step(0, 4'b0000, 4'b0000);
    check("lock_reset", 4'b0000, 2'd0);
    for (int k = 0; k < 4; k++) begin
      step(1, 4'b1111, 4'b0000);
      check("lock_pre", 4'b0001, 2'd0);
    end
    for (int k = 0; k < 10; k++) begin
      step(1, 4'b1111, 4'b0010);
      check("lock_hold", 4'b0010, 2'd1);
    end
    step(1, 4'b1111, 4'b0000);
    check("lock_release", 4'b0100, 2'd2);

    // Sole requester: continuous grant, tenures still restart every 4 cycles.
    step(0, 4'b0000, 4'b0000);
    check("sole_reset", 4'b0000, 2'd0);
    for (int k = 0; k < 11; k++) begin
      step(1, 4'b1000, 4'b0000);
      check("sole_hold", 4'b1000, 2'd3);
    end
    step(1, 4'b1001, 4'b0000);
    check("sole_no_preempt", 4'b1000, 2'd3);
    step(1, 4'b1001, 4'b0000);
    check("sole_tenure_end", 4'b0001, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
